silife_scan_ctrl: RTL and testbench
===================================

# silife_scan_ctrl

Sequencing controller for the 8x8 LED matrix scanner (`silife_scan`). It owns the scanner's configuration (`cycles`, `invert`, scanner reset) and paces the grid engine: after a programmable number of complete scan frames it requests one generation step. It captures the resulting 64-cell grid into a shadow buffer and swaps it into the displayed buffer only on a frame boundary, so no frame is drawn half-old, half-new. It sits between the config bus, the grid engine and `silife_scan`.

## Interface
- `DEF_CYCLES`, 16'd100: reset value of the per-row dwell register.
- `DEF_FPG`, 8'd4: reset value of the frames-per-generation register.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; asserting it (0) clears all state immediately.
- `cfg_we` in 1: config write strobe, one write per asserted cycle.
- `cfg_addr` in 2: 0 = cycles[15:0], 1 = ctrl {enable bit0, invert bit1}, 2 = fpg[7:0], 3 = reserved (write ignored).
- `cfg_wdata` in 16: write data.
- `cells_in` in 64: next grid from the engine, row r = bits [8r+7:8r]; valid only with `step_done`.
- `step_done` in 1: engine answer; cells_in valid this cycle.
- `step_req` out 1: request one generation step.
- `scan_cells` out 64: displayed grid to `silife_scan`.
- `scan_cycles` out 16: dwell per row to `silife_scan`.
- `scan_invert` out 1: invert to `silife_scan`.
- `scan_reset` out 1: active-high reset to `silife_scan`.
- `frame_tick` out 1: one-cycle pulse on the last cycle of each frame.
- `gen_count` out 16: number of grids swapped in; wraps at 16'hFFFF -> 0.

## Operation
- Registers: `cycles` (default DEF_CYCLES), `enable` (0), `invert` (0), `fpg` (DEF_FPG). Effective dwell D = max(cycles, 1).
- Frame model mirrors the scanner: dwell counter 0..D-1, row counter 0..7. `frame_tick` = row==7 && dwell==D-1. Counters run only while enabled and `scan_reset` is low.
- FSM states:
  - DISABLED: `scan_reset`=1, counters, frame count and shadow-valid are cleared.
  - RUN: counts frame_ticks.
  - REQ: `step_req`=1.
  - PENDING: shadow holds a new grid.
- Transitions:
  - DISABLED -> RUN on enable=1.
  - RUN -> REQ when the frame count reaches fpg; the frame count then clears.
  - REQ -> PENDING on `step_done`=1: latch cells_in into shadow on the same edge.
  - PENDING -> RUN on frame_tick: `scan_cells` <= shadow, gen_count++.
  - Any state -> DISABLED on enable=0.
- fpg==0: the controller stays in RUN, never requests, and the display freezes.
- Frame ticks during REQ/PENDING are not counted toward fpg.
- `step_done` outside REQ is ignored. No new data is latched in PENDING.
- Write to cycles: `scan_cycles` updates next edge. `scan_reset` pulses high for exactly one cycle and the internal counters restart at row 0, dwell 0, so the frame in progress produces no frame_tick. The FSM state is kept.
- Write to ctrl: `scan_invert` follows bit1 next edge with no scanner reset.
- Simultaneous events:
  - `step_done` in the same cycle as a write of enable=0: disable wins and the data is discarded.
  - cycles write on a frame_tick cycle: the restart wins, so no swap and no count.

## Timing
- Reset values:
  - `step_req`=0, `scan_cells`=0, `scan_cycles`=DEF_CYCLES, `scan_invert`=0.
  - `scan_reset`=1, `frame_tick`=0, `gen_count`=0.
  - State DISABLED.
- Enable write at edge N: `scan_reset` falls at N+1. The first frame_tick comes 8·D cycles later, and every 8·D cycles after that.
- `step_req` rises on the edge after the fpg-th counted frame_tick. It falls on the edge that samples `step_done`=1.
- Swap latency: `scan_cells` changes on the edge after the first frame_tick following capture, aligned with the scanner's return to row 0.
- All outputs are registered.
- Reset asserted mid-operation clears everything asynchronously and drops `step_req` without waiting for the engine.

## Test plan
- Reset release, no writes -> `scan_reset`=1, `scan_cycles`=100, `step_req`=0, `gen_count`=0 held indefinitely.
- Write cycles=3, fpg=2, ctrl=1 -> `frame_tick` every 24 cycles; `step_req` rises after the 2nd tick. Answer `step_done` 5 cycles later with cells_in=64'hAA66_0024_0000_0020 -> `scan_cells` takes that value one cycle after the next tick, and `gen_count`=1.
- Write cycles=0 -> D=1, `frame_tick` every 8 cycles, one `scan_reset` pulse at the write.
- Write cycles mid-frame -> one-cycle `scan_reset`, the next tick exactly 8·D cycles after the write, and the pending swap is delayed accordingly.
- Write ctrl=3 while in RUN -> `scan_invert`=1 next cycle, no `scan_reset` pulse, frame cadence unchanged.
- Write enable=0 in the same cycle as `step_done` -> DISABLED, `step_req`=0, `scan_cells` and `gen_count` unchanged. Re-enable restarts the fpg count from 0.

Source files
------------

// File: rtl/silife_scan_ctrl.sv
// silife_scan_ctrl: configuration owner and generation pacer for the 8x8 LED scanner.
// Mirrors the scanner's row/dwell counters to find frame boundaries. Every fpg frames it
// requests a grid from the engine and swaps the new grid in on the next frame boundary.
module silife_scan_ctrl #(
    parameter logic [15:0] DEF_CYCLES = 16'd100,
    parameter logic [7:0]  DEF_FPG    = 8'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    input  logic [63:0] cells_in,
    input  logic        step_done,
    output logic        step_req,
    output logic [63:0] scan_cells,
    output logic [15:0] scan_cycles,
    output logic        scan_invert,
    output logic        scan_reset,
    output logic        frame_tick,
    output logic [15:0] gen_count
);

    localparam int unsigned DWELL_W = 16;
    localparam int unsigned ROW_W   = 3;
    localparam int unsigned FPG_W   = 8;

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_RUN,
        ST_REQ,
        ST_PENDING
    } state_t;

    state_t               state;
    logic                 enable;
    logic [FPG_W-1:0]     fpg;
    logic [FPG_W-1:0]     frame_cnt;
    logic [63:0]          shadow;
    logic [DWELL_W-1:0]   dwell;
    logic [ROW_W-1:0]     row;

    logic [DWELL_W-1:0]   d_eff;
    logic                 cyc_wr;
    logic                 ctrl_wr;
    logic                 fpg_wr;
    logic                 en_next;
    logic                 counting;
    logic                 pre_end;
    logic                 tick_ev;
    logic                 fpg_hit;

    // Decode config writes and the frame-position helpers.
    always_comb begin
        d_eff    = (scan_cycles == 16'd0) ? 16'd1 : scan_cycles;
        cyc_wr   = cfg_we && (cfg_addr == 2'd0);
        ctrl_wr  = cfg_we && (cfg_addr == 2'd1);
        fpg_wr   = cfg_we && (cfg_addr == 2'd2);
        en_next  = ctrl_wr ? cfg_wdata[0] : enable;
        counting = enable && !scan_reset;
        // pre_end: the position whose successor is the last cycle of the frame
        if (d_eff == 16'd1) begin
            pre_end = (row == 3'd6);
        end else begin
            pre_end = (row == 3'd7) && (dwell == (d_eff - 16'd2));
        end
        // a cycles write on the tick cycle restarts the frame, so the tick is void
        tick_ev  = frame_tick && !cyc_wr;
        fpg_hit  = ({1'b0, frame_cnt} + 9'd1) >= {1'b0, fpg};
    end

    // Configuration registers; scan_cycles doubles as the dwell register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cycles <= DEF_CYCLES;
            scan_invert <= 1'b0;
            enable      <= 1'b0;
            fpg         <= DEF_FPG;
        end else begin
            if (cyc_wr) begin
                scan_cycles <= cfg_wdata;
            end
            if (ctrl_wr) begin
                enable      <= cfg_wdata[0];
                scan_invert <= cfg_wdata[1];
            end
            if (fpg_wr) begin
                fpg <= cfg_wdata[FPG_W-1:0];
            end
        end
    end

    // Frame model: dwell/row counters tracking the scanner, plus the registered frame tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell      <= '0;
            row        <= '0;
            frame_tick <= 1'b0;
        end else begin
            if (cyc_wr || !counting || !en_next) begin
                dwell <= '0;
                row   <= '0;
            end else if (dwell == (d_eff - 16'd1)) begin
                dwell <= '0;
                row   <= row + 3'd1;
            end else begin
                dwell <= dwell + 16'd1;
            end
            frame_tick <= counting && en_next && !cyc_wr && pre_end;
        end
    end

    // Sequencing FSM: frame counting, step request, grid capture and boundary swap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_DISABLED;
            step_req   <= 1'b0;
            scan_reset <= 1'b1;
            frame_cnt  <= '0;
            shadow     <= '0;
            scan_cells <= '0;
            gen_count  <= '0;
        end else if (!en_next) begin
            // disable wins over everything, including a same-cycle step_done
            state      <= ST_DISABLED;
            step_req   <= 1'b0;
            scan_reset <= 1'b1;
            frame_cnt  <= '0;
        end else begin
            scan_reset <= cyc_wr;
            case (state)
                ST_DISABLED: begin
                    step_req  <= 1'b0;
                    frame_cnt <= '0;
                    if (enable) begin
                        state <= ST_RUN;
                    end else begin
                        scan_reset <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tick_ev && (fpg != 8'd0)) begin
                        if (fpg_hit) begin
                            state     <= ST_REQ;
                            step_req  <= 1'b1;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                ST_REQ: begin
                    if (step_done) begin
                        state    <= ST_PENDING;
                        step_req <= 1'b0;
                        shadow   <= cells_in;
                    end
                end
                ST_PENDING: begin
                    if (tick_ev) begin
                        state      <= ST_RUN;
                        scan_cells <= shadow;
                        gen_count  <= gen_count + 16'd1;
                    end
                end
                default: begin
                    state <= ST_DISABLED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_silife_scan_ctrl.sv
// Directed bench for silife_scan_ctrl: cadence, request/answer, swap timing, restarts.
module tb_silife_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [63:0] cells_in;
    logic        step_done;
    logic        step_req;
    logic [63:0] scan_cells;
    logic [15:0] scan_cycles;
    logic        scan_invert;
    logic        scan_reset;
    logic        frame_tick;
    logic [15:0] gen_count;

    int checks   = 0;
    int failures = 0;
    int ticks    = 0;

    localparam logic [63:0] C1 = 64'hAA66_0024_0000_0020;
    localparam logic [63:0] C2 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] C3 = 64'hDEAD_BEEF_0000_FFFF;
    localparam logic [63:0] CX = 64'h1111_2222_3333_4444;

    silife_scan_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cells_in    (cells_in),
        .step_done   (step_done),
        .step_req    (step_req),
        .scan_cells  (scan_cells),
        .scan_cycles (scan_cycles),
        .scan_invert (scan_invert),
        .scan_reset  (scan_reset),
        .frame_tick  (frame_tick),
        .gen_count   (gen_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame ticks as seen at each rising edge.
    always @(posedge clk) begin
        if (frame_tick) ticks <= ticks + 1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    // Edges until frame_tick is seen high; 0 when the budget runs out.
    task automatic wait_tick(output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        for (int i = 1; i <= 200; i++) begin
            if (!got) begin
                tick();
                if (frame_tick) begin
                    n   = i;
                    got = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int n;
        int snap;
        bit req_seen;

        reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        cells_in = '0; step_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scan_reset", 64'(scan_reset), 64'd1);
        chk("rst_scan_cycles", 64'(scan_cycles), 64'd100);
        chk("rst_step_req", 64'(step_req), 64'd0);
        chk("rst_scan_cells", scan_cells, 64'd0);

        reset = 1'b1;
        repeat (50) tick();
        chk("idle_scan_reset", 64'(scan_reset), 64'd1);
        chk("idle_scan_cycles", 64'(scan_cycles), 64'd100);
        chk("idle_step_req", 64'(step_req), 64'd0);
        chk("idle_gen_count", 64'(gen_count), 64'd0);
        chk("idle_no_ticks", 64'(ticks), 64'd0);
        chk("idle_invert", 64'(scan_invert), 64'd0);

        // cycles=3, fpg=2, enable
        cfg_write(2'd0, 16'd3);
        cfg_write(2'd2, 16'd2);
        chk("cyc3_scan_cycles", 64'(scan_cycles), 64'd3);
        cfg_write(2'd1, 16'd1);
        chk("en_srst_edge", 64'(scan_reset), 64'd1);
        tick();
        chk("en_srst_fall", 64'(scan_reset), 64'd0);
        wait_tick(n); chk("gap_first", 64'(n), 64'd23);
        wait_tick(n); chk("gap_second", 64'(n), 64'd24);
        chk("req_before", 64'(step_req), 64'd0);
        tick();
        chk("req_rise", 64'(step_req), 64'd1);
        repeat (4) tick();
        chk("req_held", 64'(step_req), 64'd1);
        step_done = 1'b1; cells_in = C1;
        tick();
        step_done = 1'b0; cells_in = '0;
        chk("req_fall", 64'(step_req), 64'd0);
        chk("no_early_swap", scan_cells, 64'd0);
        wait_tick(n); chk("gap_pending", 64'(n), 64'd18);
        chk("swap_not_yet", scan_cells, 64'd0);
        tick();
        chk("swap1_cells", scan_cells, C1);
        chk("swap1_gen", 64'(gen_count), 64'd1);

        // invert write in RUN: no restart
        cfg_write(2'd1, 16'd3);
        chk("inv_set", 64'(scan_invert), 64'd1);
        chk("inv_no_srst", 64'(scan_reset), 64'd0);
        wait_tick(n); chk("gap_inv", 64'(n), 64'd22);

        // step_done outside REQ is ignored
        step_done = 1'b1; cells_in = CX;
        tick();
        step_done = 1'b0; cells_in = '0;
        chk("stray_no_req", 64'(step_req), 64'd0);
        wait_tick(n); chk("gap_run2", 64'(n), 64'd23);
        tick();
        chk("req2_rise", 64'(step_req), 64'd1);
        step_done = 1'b1; cells_in = C2;
        tick();
        step_done = 1'b0; cells_in = '0;
        chk("stray_not_shown", scan_cells, C1);

        // cycles=0 mid-frame while pending
        repeat (7) tick();
        cfg_write(2'd0, 16'd0);
        chk("cyc0_srst", 64'(scan_reset), 64'd1);
        chk("cyc0_cycles", 64'(scan_cycles), 64'd0);
        tick();
        chk("cyc0_srst_one", 64'(scan_reset), 64'd0);
        wait_tick(n); chk("gap_cyc0", 64'(n), 64'd7);
        chk("swap2_delayed", scan_cells, C1);
        tick();
        chk("swap2_cells", scan_cells, C2);
        chk("swap2_gen", 64'(gen_count), 64'd2);
        wait_tick(n); chk("gap_d1_a", 64'(n), 64'd7);
        wait_tick(n); chk("gap_d1_b", 64'(n), 64'd8);
        tick();
        chk("req3_rise", 64'(step_req), 64'd1);
        step_done = 1'b1; cells_in = C3;
        tick();
        step_done = 1'b0; cells_in = '0;
        wait_tick(n); chk("gap_d1_c", 64'(n), 64'd6);

        // cycles write on the tick cycle: restart wins
        cfg_write(2'd0, 16'd2);
        chk("tickwr_cells", scan_cells, C2);
        chk("tickwr_gen", 64'(gen_count), 64'd2);
        chk("tickwr_srst", 64'(scan_reset), 64'd1);
        tick();
        wait_tick(n); chk("gap_d2", 64'(n), 64'd15);
        chk("swap3_delayed", scan_cells, C2);
        tick();
        chk("swap3_cells", scan_cells, C3);
        chk("swap3_gen", 64'(gen_count), 64'd3);
        wait_tick(n); chk("gap_d2_a", 64'(n), 64'd15);
        wait_tick(n); chk("gap_d2_b", 64'(n), 64'd16);
        tick();
        chk("req4_rise", 64'(step_req), 64'd1);

        // disable together with step_done: disable wins
        step_done = 1'b1; cells_in = '1;
        cfg_write(2'd1, 16'd0);
        step_done = 1'b0; cells_in = '0;
        chk("dis_req", 64'(step_req), 64'd0);
        chk("dis_srst", 64'(scan_reset), 64'd1);
        chk("dis_cells", scan_cells, C3);
        chk("dis_gen", 64'(gen_count), 64'd3);
        snap = ticks;
        repeat (30) tick();
        chk("dis_no_ticks", 64'(ticks), 64'(snap));
        chk("dis_cells_hold", scan_cells, C3);

        // re-enable: fpg count starts from 0
        cfg_write(2'd1, 16'd1);
        tick();
        wait_tick(n); chk("reen_gap_a", 64'(n), 64'd15);
        chk("reen_no_req", 64'(step_req), 64'd0);
        wait_tick(n); chk("reen_gap_b", 64'(n), 64'd16);
        tick();
        chk("reen_req", 64'(step_req), 64'd1);

        // asynchronous reset mid-request
        #2;
        reset = 1'b0;
        #1;
        chk("arst_req", 64'(step_req), 64'd0);
        chk("arst_cells", scan_cells, 64'd0);
        chk("arst_gen", 64'(gen_count), 64'd0);
        chk("arst_srst", 64'(scan_reset), 64'd1);
        chk("arst_cycles", 64'(scan_cycles), 64'd100);
        tick();
        reset = 1'b1;
        tick();

        // fpg=0: ticks keep coming, no requests
        cfg_write(2'd0, 16'd0);
        cfg_write(2'd2, 16'd0);
        cfg_write(2'd1, 16'd1);
        snap = ticks;
        req_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (step_req) req_seen = 1'b1;
        end
        chk("fpg0_ticks", 64'(ticks - snap), 64'd7);
        chk("fpg0_no_req", 64'(req_seen), 64'd0);
        chk("fpg0_gen", 64'(gen_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
